// File: rtl/pwm_mixer_nch.sv
// N-channel PWM mixer: debounced inc/dec buttons step the duty of the selected
// channel; duties are shadow-buffered and loaded into all channels at period end.
module pwm_mixer_nch #(
    parameter int N_CH          = 3,
    parameter int CLK_FREQ      = 50_000_000,
    parameter int PWM_FREQ      = 10_000,
    parameter int DEBOUNCE_FREQ = 1_000_000,
    parameter int STEP          = 32,
    parameter int REPEAT_TICKS  = 0,
    parameter int SEL_W         = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int DUTY_W        = $clog2(CLK_FREQ / PWM_FREQ + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic [SEL_W-1:0]  led,
    output logic [N_CH-1:0]   pwm,
    output logic [DUTY_W-1:0] duty_rd,
    output logic              period_start
);
    localparam int PERIOD   = CLK_FREQ / PWM_FREQ;
    localparam int TICK_DIV = CLK_FREQ / DEBOUNCE_FREQ;
    localparam int TDIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TICK_DIV - 1);
    localparam logic [DUTY_W-1:0] CNT_LAST  = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] PERIOD_D  = DUTY_W'(PERIOD);
    localparam logic [DUTY_W:0]   PERIOD_X  = (DUTY_W + 1)'(PERIOD);
    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);

    // Bit 0 is the inc button, bit 1 the dec button throughout.
    logic [1:0]        sync1_q, sync2_q;
    logic [1:0]        press_ev;
    logic [TDIV_W-1:0] tdiv_q;
    logic              tick;

    assign tick = (tdiv_q == TDIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            tdiv_q  <= '0;
        end else begin
            sync1_q <= {dec, inc};
            sync2_q <= sync1_q;
            tdiv_q  <= tick ? '0 : tdiv_q + 1'b1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [2:0] hist_q, hist_d;
        logic       deb_q, deb_d, deb_prev_q, rpt_ev;

        always_comb begin
            hist_d = hist_q;
            deb_d  = deb_q;
            if (tick) begin
                hist_d = {hist_q[1:0], sync2_q[b]};
                if (hist_d == 3'b111)      deb_d = 1'b1;
                else if (hist_d == 3'b000) deb_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                hist_q     <= '0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
            end else begin
                hist_q     <= hist_d;
                deb_q      <= deb_d;
                deb_prev_q <= deb_q;
            end
        end

        if (REPEAT_TICKS > 0) begin : g_rpt
            localparam int RPT_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
            localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);
            logic [RPT_W-1:0] rpt_q;

            // Counts ticks only while held; a release restarts the interval.
            assign rpt_ev = deb_q && tick && (rpt_q == RPT_LAST);

            always_ff @(posedge clk) begin
                if (rst || !deb_q) rpt_q <= '0;
                else if (tick)     rpt_q <= (rpt_q == RPT_LAST) ? '0 : rpt_q + 1'b1;
            end
        end else begin : g_no_rpt
            assign rpt_ev = 1'b0;
        end

        assign press_ev[b] = (deb_q & ~deb_prev_q) | rpt_ev;
    end

    logic [DUTY_W-1:0] shadow_q [N_CH];
    logic [DUTY_W-1:0] shadow_d [N_CH];
    logic [DUTY_W-1:0] active_q [N_CH];
    logic [DUTY_W-1:0] cnt_q;
    logic [N_CH-1:0]   pwm_q;
    logic [DUTY_W:0]   sum_x, diff_x;
    logic              cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        sum_x  = '0;
        diff_x = '0;
        for (int i = 0; i < N_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            // Simultaneous inc+dec cancel; out-of-range selects match no channel.
            if (led == SEL_W'(i) && (press_ev[0] ^ press_ev[1])) begin
                sum_x  = {1'b0, shadow_q[i]} + STEP_X;
                diff_x = {1'b0, shadow_q[i]} - STEP_X;
                if (press_ev[0]) shadow_d[i] = (sum_x > PERIOD_X) ? PERIOD_D : sum_x[DUTY_W-1:0];
                else             shadow_d[i] = diff_x[DUTY_W] ? '0 : diff_x[DUTY_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            pwm_q <= '0;
            // NOTE: the duty arrays are plain flops, so they take the reset like any register.
            for (int i = 0; i < N_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                // Loading from shadow_d lets a write in the last cycle join this load.
                if (cnt_last) active_q[i] <= shadow_d[i];
                pwm_q[i] <= (cnt_q < active_q[i]);
            end
        end
    end

    always_comb begin
        duty_rd = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (led == SEL_W'(i)) duty_rd = shadow_q[i];
        end
    end

    assign pwm          = pwm_q;
    assign period_start = !rst && (cnt_q == '0);

endmodule

// File: tb/tb_pwm_mixer_nch.sv
// Scoreboard bench for pwm_mixer_nch using a scaled clock: PERIOD=100,
// TICK_DIV=4, STEP=8; a second instance exercises auto-repeat.
module tb_pwm_mixer_nch;
    localparam int CLK_F = 1_000_000;
    localparam int PWM_F = 10_000;
    localparam int DEB_F = 250_000;
    localparam int STP   = 8;
    localparam int P     = CLK_F / PWM_F;
    localparam int NC    = 3;
    localparam int DW    = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inc_a = 1'b0, dec_a = 1'b0;
    logic [1:0]    led_a = '0;
    logic [NC-1:0] pwm_a;
    logic [DW-1:0] duty_rd_a;
    logic          ps_a;
    logic          inc_b = 1'b0, dec_b = 1'b0;
    logic [1:0]    led_b = '0;
    logic [NC-1:0] pwm_b;
    logic [DW-1:0] duty_rd_b;
    logic          ps_b;

    int checks   = 0;
    int failures = 0;
    int exp_sh [NC];
    int exp_q [$];
    int hcnt [NC];

    always #5 clk = ~clk;

    pwm_mixer_nch #(.N_CH(NC), .CLK_FREQ(CLK_F), .PWM_FREQ(PWM_F), .DEBOUNCE_FREQ(DEB_F),
                    .STEP(STP), .REPEAT_TICKS(0)) dut (
        .clk(clk), .rst(rst), .inc(inc_a), .dec(dec_a), .led(led_a),
        .pwm(pwm_a), .duty_rd(duty_rd_a), .period_start(ps_a));

    pwm_mixer_nch #(.N_CH(NC), .CLK_FREQ(CLK_F), .PWM_FREQ(PWM_F), .DEBOUNCE_FREQ(DEB_F),
                    .STEP(STP), .REPEAT_TICKS(10)) dut_rpt (
        .clk(clk), .rst(rst), .inc(inc_b), .dec(dec_b), .led(led_b),
        .pwm(pwm_b), .duty_rd(duty_rd_b), .period_start(ps_b));

    // Reference model of one press event on the shadow duties; pushes the
    // duty_rd value the DUT should then show.
    function automatic void model_ev(input bit pi, input bit pd, input int sel);
        if ((pi ^ pd) && sel < NC) begin
            if (pi) exp_sh[sel] = (exp_sh[sel] + STP > P) ? P : exp_sh[sel] + STP;
            else    exp_sh[sel] = (exp_sh[sel] < STP) ? 0 : exp_sh[sel] - STP;
        end
        exp_q.push_back((sel < NC) ? exp_sh[sel] : 0);
    endfunction

    task automatic press(input bit pi, input bit pd, input int hold);
        @(posedge clk); #1;
        inc_a = pi;
        dec_a = pd;
        repeat (hold) @(posedge clk);
        #1;
        inc_a = 1'b0;
        dec_a = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        model_ev(pi, pd, int'(led_a));
    endtask

    task automatic sync_ps();
        int budget;
        budget = 0;
        @(negedge clk);
        while (!ps_a && budget < 3 * P) begin
            @(negedge clk);
            budget++;
        end
        if (!ps_a) begin
            checks++;
            failures++;
            $display("FAIL sync_ps: no period_start within %0d cycles", 3 * P);
        end
    endtask

    // Starting on a period_start negedge, counts high cycles per channel over
    // one period and ends on the next period_start negedge.
    task automatic window();
        for (int c = 0; c < NC; c++) hcnt[c] = 0;
        repeat (P) begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) if (pwm_a[c]) hcnt[c]++;
        end
    endtask

    task automatic test_reset();
        int ps_cnt, last_ps, gap_bad, pwm_bad, rd_bad;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (pwm_a !== 3'b000) begin failures++; $display("FAIL reset_pwm: got %b want 000", pwm_a); end
        checks++; if (ps_a !== 1'b0) begin failures++; $display("FAIL reset_ps: got %b want 0", ps_a); end
        checks++; if (duty_rd_a !== 7'd0) begin failures++; $display("FAIL reset_rd: got %0d want 0", duty_rd_a); end
        @(posedge clk); #1;
        rst = 1'b0;
        ps_cnt = 0; last_ps = -1; gap_bad = 0; pwm_bad = 0; rd_bad = 0;
        for (int i = 0; i < 2 * P + 50; i++) begin
            @(negedge clk);
            if (ps_a) begin
                if (last_ps >= 0 && i - last_ps != P) gap_bad++;
                last_ps = i;
                ps_cnt++;
            end
            if (pwm_a !== 3'b000) pwm_bad++;
            if (duty_rd_a !== 7'd0) rd_bad++;
        end
        checks++; if (ps_cnt != 3) begin failures++; $display("FAIL idle_ps_count: got %0d want 3", ps_cnt); end
        checks++; if (gap_bad != 0) begin failures++; $display("FAIL idle_ps_gap: %0d bad gaps want 0", gap_bad); end
        checks++; if (pwm_bad != 0) begin failures++; $display("FAIL idle_pwm: %0d nonzero cycles want 0", pwm_bad); end
        checks++; if (rd_bad != 0) begin failures++; $display("FAIL idle_rd: %0d nonzero cycles want 0", rd_bad); end
    endtask

    task automatic test_bounce();
        int dur [9] = '{3, 6, 5, 10, 60, 10, 5, 6, 3};
        int e;
        led_a = 2'd0;
        @(posedge clk); #1;
        for (int k = 0; k < 9; k++) begin
            inc_a = (k % 2 == 0);
            repeat (dur[k]) @(posedge clk);
            #1;
        end
        inc_a = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        model_ev(1'b1, 1'b0, 0);
        e = exp_q.pop_front();
        checks++; if (duty_rd_a !== DW'(e)) begin failures++; $display("FAIL bounce_rd: got %0d want %0d", duty_rd_a, e); end
        sync_ps();
        for (int w = 0; w < 2; w++) begin
            exp_q.push_back(exp_sh[0]);
            window();
            e = exp_q.pop_front();
            checks++; if (hcnt[0] != e) begin failures++; $display("FAIL bounce_pwm0 w%0d: got %0d want %0d", w, hcnt[0], e); end
            checks++; if (hcnt[1] != 0 || hcnt[2] != 0) begin failures++; $display("FAIL bounce_pwm21 w%0d: got %0d/%0d want 0/0", w, hcnt[1], hcnt[2]); end
        end
    endtask

    task automatic test_saturate();
        int e, bad;
        led_a = 2'd1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            press(1'b1, 1'b0, 24);
            e = exp_q.pop_front();
            checks++; if (duty_rd_a !== DW'(e)) begin failures++; bad++; $display("FAIL inc_rd #%0d: got %0d want %0d", k, duty_rd_a, e); end
        end
        sync_ps();
        window();
        checks++; if (hcnt[1] != P) begin failures++; $display("FAIL full_pwm1: got %0d want %0d", hcnt[1], P); end
        checks++; if (hcnt[0] != exp_sh[0]) begin failures++; $display("FAIL full_pwm0: got %0d want %0d", hcnt[0], exp_sh[0]); end
        for (int k = 0; k < 15; k++) begin
            press(1'b0, 1'b1, 24);
            e = exp_q.pop_front();
            checks++; if (duty_rd_a !== DW'(e)) begin failures++; $display("FAIL dec_rd #%0d: got %0d want %0d", k, duty_rd_a, e); end
        end
        sync_ps();
        window();
        checks++; if (hcnt[1] != 0) begin failures++; $display("FAIL zero_pwm1: got %0d want 0", hcnt[1]); end
    endtask

    task automatic test_shadow();
        int e;
        led_a = 2'd2;
        press(1'b1, 1'b0, 24);
        void'(exp_q.pop_front());
        press(1'b1, 1'b0, 24);
        e = exp_q.pop_front();
        checks++; if (duty_rd_a !== DW'(e)) begin failures++; $display("FAIL shadow_pre_rd: got %0d want %0d", duty_rd_a, e); end
        sync_ps();
        exp_q.push_back(exp_sh[2]);
        fork
            window();
            begin
                repeat (40) @(posedge clk);
                press(1'b1, 1'b0, 24);
            end
        join
        e = exp_q.pop_front();
        checks++; if (hcnt[2] != e) begin failures++; $display("FAIL shadow_old_duty: got %0d want %0d", hcnt[2], e); end
        e = exp_q.pop_front();
        checks++; if (duty_rd_a !== DW'(e)) begin failures++; $display("FAIL shadow_mid_rd: got %0d want %0d", duty_rd_a, e); end
        exp_q.push_back(exp_sh[2]);
        window();
        e = exp_q.pop_front();
        checks++; if (hcnt[2] != e) begin failures++; $display("FAIL shadow_new_duty: got %0d want %0d", hcnt[2], e); end
    endtask

    task automatic test_repeat();
        int e;
        // Held 95 ticks: 1 press event + 9 repeats at 10-tick intervals.
        @(posedge clk); #1;
        inc_b = 1'b1;
        repeat (380) @(posedge clk);
        #1;
        inc_b = 1'b0;
        exp_q.push_back(10 * STP);
        repeat (100) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++; if (duty_rd_b !== DW'(e)) begin failures++; $display("FAIL repeat_rd: got %0d want %0d", duty_rd_b, e); end
        exp_q.push_back(10 * STP);
        repeat (200) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++; if (duty_rd_b !== DW'(e)) begin failures++; $display("FAIL repeat_release_rd: got %0d want %0d", duty_rd_b, e); end
    endtask

    task automatic test_misc_reset();
        int e;
        logic [NC-1:0] exp_pwm;
        led_a = 2'd3;
        press(1'b1, 1'b0, 24);
        e = exp_q.pop_front();
        checks++; if (duty_rd_a !== DW'(e)) begin failures++; $display("FAIL led3_rd: got %0d want %0d", duty_rd_a, e); end
        for (int c = 0; c < NC; c++) begin
            led_a = 2'(c);
            #1;
            checks++; if (duty_rd_a !== DW'(exp_sh[c])) begin failures++; $display("FAIL led3_ch%0d: got %0d want %0d", c, duty_rd_a, exp_sh[c]); end
        end
        led_a = 2'd2;
        press(1'b1, 1'b1, 24);
        e = exp_q.pop_front();
        checks++; if (duty_rd_a !== DW'(e)) begin failures++; $display("FAIL both_rd: got %0d want %0d", duty_rd_a, e); end
        sync_ps();
        repeat (5) @(negedge clk);
        for (int c = 0; c < NC; c++) exp_pwm[c] = (4 < exp_sh[c]);
        checks++; if (pwm_a !== exp_pwm) begin failures++; $display("FAIL pre_reset_pwm: got %b want %b", pwm_a, exp_pwm); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (pwm_a !== 3'b000) begin failures++; $display("FAIL midrst_pwm: got %b want 000", pwm_a); end
        checks++; if (ps_a !== 1'b0) begin failures++; $display("FAIL midrst_ps: got %b want 0", ps_a); end
        checks++; if (duty_rd_a !== 7'd0) begin failures++; $display("FAIL midrst_rd: got %0d want 0", duty_rd_a); end
        checks++; if (duty_rd_b !== 7'd0) begin failures++; $display("FAIL midrst_rd_b: got %0d want 0", duty_rd_b); end
        for (int c = 0; c < NC; c++) exp_sh[c] = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        sync_ps();
        window();
        checks++; if (hcnt[0] != 0 || hcnt[1] != 0 || hcnt[2] != 0) begin
            failures++;
            $display("FAIL post_rst_pwm: got %0d/%0d/%0d want 0/0/0", hcnt[0], hcnt[1], hcnt[2]);
        end
    endtask

    initial begin
        for (int c = 0; c < NC; c++) exp_sh[c] = 0;
        test_reset();
        test_bounce();
        test_saturate();
        test_shadow();
        test_repeat();
        test_misc_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_mixer_nch.md
Name: pwm_mixer_nch

Overview:
Parametrised N-channel successor to the 3-LED RGB mixer. Two push-button inputs (inc/dec) are synchronised, debounced and edge-detected, with optional auto-repeat while held. Each press steps the duty of the channel chosen by `led`, saturating at 0 and at PERIOD. Duty values are shadow-buffered and take effect only at a PWM period boundary, so no output ever sees a glitched period. Sits between board buttons/switches and the LED drivers.

Parameters:
N_CH, 3, number of PWM channels (1..16)
CLK_FREQ, 50000000, clk frequency in Hz
PWM_FREQ, 10000, PWM frequency in Hz; PERIOD = CLK_FREQ/PWM_FREQ (5000 default)
DEBOUNCE_FREQ, 1000000, debounce sample-tick rate; TICK_DIV = CLK_FREQ/DEBOUNCE_FREQ (50 default)
STEP, 32, duty increment/decrement per press, in clk cycles
REPEAT_TICKS, 0, auto-repeat interval in sample ticks while a button is held; 0 disables auto-repeat
SEL_W, $clog2(N_CH) min 1, width of `led`
DUTY_W, $clog2(PERIOD+1), duty register width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
inc  in  1  raw increment button, asynchronous, bouncy
dec  in  1  raw decrement button, asynchronous, bouncy
led  in  SEL_W  channel select, sampled on each press event
pwm  out  N_CH  PWM outputs, bit i = channel i
duty_rd  out  DUTY_W  pending (shadow) duty of the channel selected by `led`; 0 if led>=N_CH
period_start  out  1  one-cycle pulse when the period counter is 0

Behaviour:
- Reset (sync, rst=1 at a clk edge): period cnt=0, tick div=0, all shadow and active duties=0, debounced states=0, repeat counters=0, pwm=0, period_start=0. Mid-operation reset wipes all state on the next edge.
- Sync: inc and dec each pass through 2 flops before any other logic.
- Sample tick: one-cycle pulse every TICK_DIV cycles, free-running from reset.
- Debounce: on each tick, shift the synced level into a 3-bit history per button. The debounced state becomes 1 when the history is 111 and 0 when it is 000; otherwise it holds.
- Press event: one-cycle pulse on the clk after the debounced state rises 0->1.
- Auto-repeat (REPEAT_TICKS>0): while the debounced state stays 1, an extra event fires every REPEAT_TICKS ticks after the initial press. The repeat counter clears when the debounced state falls.
- Events:
  - inc event: shadow[led] = min(shadow[led]+STEP, PERIOD).
  - dec event: shadow[led] = max(shadow[led]-STEP, 0). Compute at DUTY_W+1 bits; no wrap.
  - inc and dec events in the same cycle: no change.
  - led>=N_CH: event ignored.
- Period counter: 0..PERIOD-1, wraps to 0. period_start=1 when cnt==0.
- Active duty: when cnt==PERIOD-1, active[i] <= shadow[i] for all i simultaneously. A new duty first shows on the period starting at the next cnt==0. Shadow writes in the cycle where cnt==PERIOD-1 are captured by that same load.
- Output: pwm[i] registered = (cnt < active[i]).
  - duty 0 gives constant low; duty PERIOD gives constant high.
  - The high pulse lasts exactly active[i] cycles per period, 1-cycle register latency after cnt.
- duty_rd: combinational read of shadow[led].

Test Plan:
1. Reset held 5 cycles then released; no buttons pressed -> pwm=000 and duty_rd=0 for 20000 cycles; period_start pulses every 5000 cycles.
2. led=0; inc bounced (3 on / 6 off / 5 on / 10 off), then held 200 cycles and released with mirrored bounce -> exactly one event; shadow[0]=32; pwm[0] high for exactly 32 cycles in each following period; pwm[2:1]=0.
3. led=1; 160 clean inc presses (400-cycle period each) -> shadow[1] saturates at 5000 after 157 presses; pwm[1] constant high. Then 200 dec presses -> shadow[1]=0, pwm[1] constant low, no wrap.
4. led=2; shadow write issued mid-period (cnt=2500) -> current period keeps the old duty; new duty is first visible at the next cnt==0.
5. REPEAT_TICKS=100, led=0; inc held 1 ms (50000 cycles) -> 1 initial event plus 9 repeats; shadow[0]=320. Release -> no further events.
6. led=3 with N_CH=3 -> inc/dec ignored, duty_rd=0. Simultaneous inc+dec press -> all duties unchanged. rst asserted mid-period with duties nonzero -> all pwm=0 on the next edge.
